seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001: Parameter N, default 8, sets the operand, quotient and remainder width in bits; legal range is 2..32.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: in_valid  input  1  dividend and divisor are presented for acceptance.
REQ-005: in_ready  output  1  block can accept a new operation.
REQ-006: dividend  input  N  unsigned dividend.
REQ-007: divisor  input  N  unsigned divisor.
REQ-008: out_valid  output  1  quotient and remainder are valid.
REQ-009: out_ready  input  1  consumer accepts the result.
REQ-010: quotient  output  N  unsigned quotient.
REQ-011: remainder  output  N  unsigned remainder.
REQ-012: div_zero  output  1  divisor was zero; present only when DIV_ZERO_FLAG_EN is defined.

Function
REQ-013: The FSM SHALL have exactly 3 states: IDLE, BUSY and DONE.
REQ-014: in_ready SHALL be 1 in IDLE and 0 in all other states; out_valid SHALL be 1 in DONE and 0 in all other states.
REQ-015: An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; on that edge the block SHALL latch dividend and divisor, clear the partial remainder and iteration counter, and enter BUSY.
REQ-016: In BUSY the block SHALL perform one restoring-division step per cycle, MSB first.
- Each step: shift the partial remainder left by 1 and append the next dividend bit.
- Trial-subtract the divisor using an (N+1)-bit subtraction.
- If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
REQ-017: After exactly N BUSY cycles the block SHALL enter DONE, so out_valid rises on the Nth rising edge after the accept edge.
REQ-018: In DONE, quotient, remainder and div_zero SHALL hold stable while out_ready=0.
REQ-019: A rising edge in DONE with out_ready=1 SHALL move the block to IDLE; in_ready SHALL rise in the following cycle, with no same-cycle turnaround.
REQ-020: in_valid and operand changes after the accept edge SHALL have no effect on the operation in flight.
REQ-021: Divisor = 0 SHALL complete through the normal N-cycle path, giving quotient = all ones and remainder = dividend.
REQ-022: Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0, remainder = dividend).
REQ-023: quotient and remainder SHALL be driven only from registers.

Reset
REQ-024: While rst=1 the block SHALL force state to IDLE and clear to 0 the following, regardless of clock:
- quotient, remainder, div_zero
- the iteration counter and all internal operand registers
REQ-025: Reset asserted in BUSY or DONE SHALL abort the operation, drop out_valid to 0 and raise in_ready to 1.
REQ-026: No result from an aborted operation SHALL ever appear after reset deasserts.

Configuration
REQ-027: With macro DIV_ZERO_FLAG_EN defined:
- port div_zero SHALL exist.
- div_zero SHALL be registered at accept as (divisor == 0).
- div_zero SHALL be valid while out_valid=1.
REQ-028: Without DIV_ZERO_FLAG_EN:
- port div_zero and its register SHALL be absent.
- All other behaviour SHALL be identical, including the all-ones quotient for divide by zero.

Verification (N=8)
REQ-029: Accept dividend=100, divisor=7 -> out_valid rises 8 edges after the accept; quotient=14, remainder=2.
REQ-030: dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-031: dividend=37, divisor=0 -> quotient=255, remainder=37; div_zero=1 with the macro defined, port absent without it.
REQ-032: dividend=200, divisor=13 with out_ready held 0 for 5 cycles in DONE -> quotient=15 and remainder=5 stay stable and in_ready stays 0 throughout; out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-033: Accept dividend=50, divisor=3, then assert rst at BUSY cycle 4 -> out_valid=0, in_ready=1 and outputs 0 immediately; after release, dividend=9, divisor=4 -> quotient=2, remainder=1.
REQ-034: 1000 random back-to-back operations with random in_valid/out_ready stalls -> every result matches the reference model, with no lost or duplicated transactions.

Source files
------------

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - N-bit unsigned restoring sequential divider, one quotient bit per cycle
// Optional feature macro: DIV_ZERO_FLAG_EN (adds the registered div_zero output)
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic         div_zero
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  prem_q, prem_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef DIV_ZERO_FLAG_EN
    logic          dz_q, dz_d;
`endif

    logic [N:0]    shifted;
    logic          q_bit;
    logic [N-1:0]  prem_next;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        shifted   = {prem_q, dvd_q[N-1]};
        q_bit     = (shifted >= {1'b0, dvs_q});
        prem_next = q_bit ? (shifted[N-1:0] - dvs_q) : shifted[N-1:0];
    end

    // Next-state, datapath next values and handshake outputs
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d      = dz_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    prem_d  = '0;
                    cnt_d   = '0;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d    = (divisor == '0);
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                dvd_d  = {dvd_q[N-2:0], q_bit};
                prem_d = prem_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    quo_d   = {dvd_q[N-2:0], q_bit};
                    rem_d   = prem_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, partial remainder, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q   <= dz_d;
`endif
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero  = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (N=8): vector table, corner sequences, random scoreboard
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic       div_zero;
`endif

    seq_divider #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } res_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
        res_t r;
        if (b == 8'd0) begin
            r.q  = 8'hFF;
            r.r  = a;
            r.dz = 1'b1;
        end else begin
            r.q  = a / b;
            r.r  = a % b;
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input string tag);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, " in_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 8);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, " div_zero"}, div_zero, (b == 8'd0));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " in_ready_after"}, {in_ready, out_valid}, 2'b10);
    endtask

    vec_t tbl[9];
    res_t exp_q[$];

    initial begin
        logic       acc;
        logic       del;
        logic [7:0] sq;
        logic [7:0] sr;
        logic [7:0] la;
        logic [7:0] lb;
        int         sent;
        int         got;
        int         cyc;
        int         w;
        int         ov_seen;
        res_t       e;
        res_t       pv;
`ifdef DIV_ZERO_FLAG_EN
        logic       sdz;
`endif

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
        tbl[3] = '{8'd37,  8'd0,   8'd255, 8'd37};
        tbl[4] = '{8'd0,   8'd5,   8'd0,   8'd0};
        tbl[5] = '{8'd255, 8'd255, 8'd1,   8'd0};
        tbl[6] = '{8'd1,   8'd255, 8'd0,   8'd1};
        tbl[7] = '{8'd254, 8'd2,   8'd127, 8'd0};
        tbl[8] = '{8'd0,   8'd0,   8'd255, 8'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        #12;
        check("reset handshake", {in_ready, out_valid}, 2'b10);
        check("reset results", {quotient, remainder}, 16'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("reset div_zero", div_zero, 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));
        end

        // Result held stable while the consumer stalls in DONE
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd13;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            tick();
            w++;
        end
        check("stall reach done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d result", i), {quotient, remainder}, {8'd15, 8'd5});
            check($sformatf("stall%0d handshake", i), {in_ready, out_valid}, 2'b01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall release", {in_ready, out_valid}, 2'b10);

        // Reset in the middle of an operation
        in_valid = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("abort busy", {in_ready, out_valid}, 2'b00);
        rst = 1'b1;
        #1;
        check("abort handshake", {in_ready, out_valid}, 2'b10);
        check("abort results", {quotient, remainder}, 16'd0);
        tick();
        rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check("abort no stale result", ov_seen, 0);
        do_op(8'd9, 8'd4, 8'd2, 8'd1, "after_abort");

        // Random back-to-back traffic against the arithmetic model
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 1000 && cyc < 60000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
                in_valid = 1'b1;
                dividend = 8'($urandom);
                divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 40) == 0 ? 255 : $urandom);
            end
            out_ready = ($urandom_range(0, 9) < 6);
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            sq  = quotient;
            sr  = remainder;
            la  = dividend;
            lb  = divisor;
`ifdef DIV_ZERO_FLAG_EN
            sdz = div_zero;
`endif
            tick();
            cyc++;
            if (acc) begin
                pv = model(la, lb);
                exp_q.push_back(pv);
                sent++;
                in_valid = 1'b0;
                dividend = 8'($urandom);
                divisor  = 8'($urandom);
            end
            if (del) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rand%0d q_r", got), {sq, sr}, {e.q, e.r});
`ifdef DIV_ZERO_FLAG_EN
                    check($sformatf("rand%0d div_zero", got), sdz, e.dz);
`endif
                end
                got++;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("rand results received", got, 1000);
        check("rand ops sent", sent, 1000);
        check("rand scoreboard empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
